jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
Drives a bank of WIDTH gated JK latches to a requested target state. It is the write side of the JK latch interface: it converts each "target state" request into excitation-table J/K values and an EN strobe, then reads back Q to confirm the write. The driver never issues J=K=1, so level-sensitive latches cannot race. It retries a failed write a bounded number of times, then flags an error. It sits between a control sequencer (start/target/done handshake) and the latch bank (EN/J/K out, Q in).

Parameters:
WIDTH, 4, number of latches in the driven bank (1..16)
SETTLE, 2, cycles EN is held high per drive attempt (>=1)
MAX_RETRY, 3, extra drive attempts after the first before error (0..3)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only when ready=1
target  input  WIDTH  desired latch state; captured with start
ready  output  1  high in IDLE and ERROR
done  output  1  one-cycle pulse on verified write
error  output  1  high in ERROR; held until next accepted start or RST
retries  output  2  attempts beyond the first used in the current or last op
EN  output  1  latch enable to bank
J  output  WIDTH  per-bit J to bank
K  output  WIDTH  per-bit K to bank
Q  input  WIDTH  readback from bank; treated as stable while EN=0

Behaviour:
- Reset (async, immediate): state=IDLE; EN=0; J=0; K=0; done=0; error=0; retries=0; target register=0; ready=1.
- All outputs are registered except ready, which decodes state.
- States: IDLE, DRIVE, HOLD, CHECK, ERROR.
- IDLE: EN=J=K=0.
  - On start=1: capture target into tgt, clear retries and error, go to DRIVE.
- DRIVE: EN=1 for exactly SETTLE cycles, then go to HOLD. J/K are computed per bit from the Q value sampled at DRIVE entry and from tgt:
  - Q=0, tgt=0 -> J=0, K=0
  - Q=0, tgt=1 -> J=1, K=0
  - Q=1, tgt=0 -> J=0, K=1
  - Q=1, tgt=1 -> J=0, K=0
  - Excitation don't-cares resolve to 0. J&K==0 on every bit in every cycle.
- HOLD: one cycle with EN=0 and J=K=0. EN drops before data changes. Then go to CHECK.
- CHECK: one cycle with EN=0; compare Q against tgt at the exit edge.
  - Match: go to IDLE with done=1 for one cycle.
  - Mismatch and retries<MAX_RETRY: retries+1, go to DRIVE (J/K recomputed from the new Q).
  - Mismatch and retries==MAX_RETRY: go to ERROR, error=1.
- ERROR: EN=J=K=0; ready=1.
  - start=1: clear error, capture new target, go to DRIVE.
- Latency: with start accepted at edge k, a first-try success gives done high between edges k+SETTLE+2 and k+SETTLE+3. Each retry adds SETTLE+2 cycles.
- start while ready=0 is ignored. A target change mid-operation has no effect.
- A target equal to the current Q still performs one full DRIVE/HOLD/CHECK with J=K=0, and done pulses at normal latency.
- done and a new start in the same cycle: start is accepted, because state is IDLE.
- RST mid-operation: EN/J/K drop to 0 asynchronously, and the latch contents are whatever was written so far.
- retries holds its final value after done or error until the next accepted start.

Test Plan:
- Reset: RST=1 mid-DRIVE -> EN, J, K, done, error, retries all 0 in the same cycle; ready=1.
- Basic write, WIDTH=4, SETTLE=2, bench JK-latch model Q=4'b0000, target=4'b1010 -> J=1010, K=0000, EN high 2 cycles; done at edge k+4; Q=1010; retries=0.
- Mixed set/reset, Q=4'b1100, target=4'b0110 -> J=0010, K=1000; no bit ever has J=K=1; done; Q=0110.
- No-op write, Q=target=4'b0101 -> J=K=0000 with EN pulsed; done at normal latency.
- Single retry: model drops EN on the first attempt for bit 0, target=4'b0001 -> retries=1, second DRIVE J=0001; done at edge k+8.
- Stuck fault: Q[3] forced to 0, target=4'b1000, MAX_RETRY=3 -> 4 drive attempts, then error=1, retries=3, ready=1. A following start with target=0000 clears error and completes with done.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Write-side driver for a bank of gated JK latches: turns a target word into
// excitation J/K plus an EN strobe, verifies readback, retries, then flags error.
module jk_excitation_driver #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic             ready,
    output logic             done,
    output logic             error,
    output logic [1:0]       retries,
    output logic             EN,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Q
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_HOLD, S_CHECK, S_ERROR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       retr_q, retr_d;
    logic             accept;
    logic             match;

    assign accept = ((state_q == S_IDLE) || (state_q == S_ERROR)) && start;
    assign match  = (Q == tgt_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            en_q    <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            retr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            retr_q  <= retr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) state_d = S_HOLD;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_HOLD:  state_d = S_CHECK;
            S_CHECK: begin
                if (match) begin
                    state_d = S_IDLE;
                end else if (retr_q < RETRY_LIMIT) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output next values; J/K latch the excitation from Q at DRIVE entry
    // and never assert both on one bit, since ~Q&tgt and Q&~tgt are disjoint.
    always_comb begin
        tgt_d  = tgt_q;
        en_d   = 1'b0;
        j_d    = '0;
        k_d    = '0;
        done_d = 1'b0;
        err_d  = err_q;
        retr_d = retr_q;
        if (accept) begin
            tgt_d  = target;
            err_d  = 1'b0;
            retr_d = 2'd0;
        end
        if (state_q == S_CHECK) begin
            if (match)                  done_d = 1'b1;
            else if (state_d == S_DRIVE) retr_d = retr_q + 2'd1;
            else                        err_d  = 1'b1;
        end
        if (state_d == S_DRIVE) begin
            en_d = 1'b1;
            if (state_q == S_DRIVE) begin
                j_d = j_q;
                k_d = k_q;
            end else begin
                j_d = ~Q & tgt_d;
                k_d = Q & ~tgt_d;
            end
        end
    end

    assign ready   = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign done    = done_q;
    assign error   = err_q;
    assign retries = retr_q;
    assign EN      = en_q;
    assign J       = j_q;
    assign K       = k_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver driving a behavioural JK latch bank
// with optional per-attempt bit-0 drop and stuck-at-0 output mask.
module tb_jk_excitation_driver;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int MR = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic         ready, done, error, EN;
    logic [1:0]   retries;
    logic [W-1:0] J, K, Q;

    logic [W-1:0] q_lat = '0;
    logic [W-1:0] stuck_mask = '0;
    logic         en_prev = 1'b0;
    logic         jk_viol = 1'b0;
    int           attempt_idx = 0;
    int           drop_until = 0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] j1;
        logic [W-1:0] k1;
        logic [W-1:0] jl;
        logic [W-1:0] qf;
        int           lat;
        logic         err;
        logic [1:0]   retr;
    } exp_t;

    exp_t sb[$];

    jk_excitation_driver #(.WIDTH(W), .SETTLE(S), .MAX_RETRY(MR)) dut (
        .CLK(CLK), .RST(RST), .start(start), .target(target),
        .ready(ready), .done(done), .error(error), .retries(retries),
        .EN(EN), .J(J), .K(K), .Q(Q)
    );

    always #5 CLK = ~CLK;

    assign Q = q_lat & ~stuck_mask;

    // Level-sensitive latch bank, evaluated mid-cycle while EN is high.
    always @(negedge CLK) begin
        for (int i = 0; i < W; i++) begin
            if (EN && !(i == 0 && attempt_idx < drop_until)) begin
                if (J[i])      q_lat[i] <= 1'b1;
                else if (K[i]) q_lat[i] <= 1'b0;
            end
        end
        if ((J & K) != '0) jk_viol <= 1'b1;
        if (en_prev && !EN) attempt_idx <= attempt_idx + 1;
        en_prev <= EN;
    end

    function automatic exp_t mk(input logic [W-1:0] j1, input logic [W-1:0] k1,
                                input logic [W-1:0] jl, input logic [W-1:0] qf,
                                input logic [1:0] retr, input logic err);
        exp_t e;
        e.j1 = j1; e.k1 = k1; e.jl = jl; e.qf = qf; e.retr = retr; e.err = err;
        e.lat = (int'(retr) + 1) * (S + 2);
        return e;
    endfunction

    task automatic do_op(input string nm, input logic [W-1:0] tg, input exp_t e, input bit poke);
        int n, en_cnt;
        bit fin, seen;
        logic en_last;
        logic [W-1:0] j1, k1, jl;
        exp_t x;
        @(negedge CLK);
        start = 1'b1; target = tg;
        sb.push_back(e);
        @(posedge CLK); #1;
        start = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL %s accept: ready=%b error=%b required 0 0", nm, ready, error);
        end
        n = 0; en_cnt = 0; fin = 0; seen = 0; en_last = 1'b0; j1 = 'x; k1 = 'x; jl = 'x;
        while (!fin && n < 100) begin
            if (EN === 1'b1) begin
                en_cnt++;
                if (!en_last) begin
                    if (!seen) begin j1 = J; k1 = K; seen = 1; end
                    jl = J;
                end
            end
            en_last = EN;
            if (done === 1'b1 || error === 1'b1) begin
                fin = 1;
            end else begin
                @(posedge CLK); #1;
                n++;
                if (poke && n == 1) begin start = 1'b1; target = ~tg; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        x = sb.pop_front();
        n_checks++;
        if (!fin) begin
            n_fail++; $display("FAIL %s timeout: no done/error after %0d cycles", nm, n);
        end
        n_checks++;
        if (n !== x.lat) begin
            n_fail++; $display("FAIL %s latency: got %0d required %0d", nm, n, x.lat);
        end
        n_checks++;
        if (done !== !x.err || error !== x.err) begin
            n_fail++; $display("FAIL %s outcome: done=%b error=%b required err=%b", nm, done, error, x.err);
        end
        n_checks++;
        if (retries !== x.retr) begin
            n_fail++; $display("FAIL %s retries: got %0d required %0d", nm, retries, x.retr);
        end
        n_checks++;
        if (Q !== x.qf) begin
            n_fail++; $display("FAIL %s final Q: got %b required %b", nm, Q, x.qf);
        end
        n_checks++;
        if (j1 !== x.j1 || k1 !== x.k1) begin
            n_fail++; $display("FAIL %s first J/K: got %b/%b required %b/%b", nm, j1, k1, x.j1, x.k1);
        end
        n_checks++;
        if (jl !== x.jl) begin
            n_fail++; $display("FAIL %s last-attempt J: got %b required %b", nm, jl, x.jl);
        end
        n_checks++;
        if (en_cnt !== (int'(x.retr) + 1) * S) begin
            n_fail++; $display("FAIL %s EN cycles: got %0d required %0d", nm, en_cnt, (int'(x.retr) + 1) * S);
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready at end: got %b required 1", nm, ready);
        end
        @(posedge CLK); #1;
        n_checks++;
        if (done !== 1'b0 || error !== x.err || retries !== x.retr) begin
            n_fail++; $display("FAIL %s after end: done=%b error=%b retries=%0d required 0 %b %0d",
                               nm, done, error, retries, x.err, x.retr);
        end
        n_checks++;
        if (jk_viol !== 1'b0) begin
            n_fail++; $display("FAIL %s J&K overlap seen: got %b required 0", nm, jk_viol);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK); @(negedge CLK);
        n_checks++;
        if (EN !== 1'b0 || J !== '0 || K !== '0 || done !== 1'b0 || error !== 1'b0 ||
            retries !== 2'd0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: EN=%b J=%b K=%b done=%b error=%b retries=%0d ready=%b required 0 0 0 0 0 0 1",
                               EN, J, K, done, error, retries, ready);
        end
        RST = 1'b0;
        @(negedge CLK);
        start = 1'b1; target = 4'b1111;
        @(posedge CLK); #1;
        start = 1'b0;
        n_checks++;
        if (EN !== 1'b1 || J !== 4'b1111 || K !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pre_drive: EN=%b J=%b K=%b required 1 1111 0000", EN, J, K);
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if (EN !== 1'b0 || J !== '0 || K !== '0 || done !== 1'b0 || error !== 1'b0 ||
            retries !== 2'd0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_drive: EN=%b J=%b K=%b done=%b error=%b retries=%0d ready=%b required 0 0 0 0 0 0 1",
                               EN, J, K, done, error, retries, ready);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        do_op("clear", 4'b0000, mk(4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0), 0);
        do_op("basic", 4'b1010, mk(4'b1010, 4'b0000, 4'b1010, 4'b1010, 2'd0, 1'b0), 1);
    endtask

    task automatic test_mixed();
        do_op("prep_1100", 4'b1100, mk(4'b0100, 4'b0010, 4'b0100, 4'b1100, 2'd0, 1'b0), 0);
        do_op("mixed", 4'b0110, mk(4'b0010, 4'b1000, 4'b0010, 4'b0110, 2'd0, 1'b0), 0);
    endtask

    task automatic test_noop();
        do_op("prep_0101", 4'b0101, mk(4'b0001, 4'b0010, 4'b0001, 4'b0101, 2'd0, 1'b0), 0);
        do_op("noop", 4'b0101, mk(4'b0000, 4'b0000, 4'b0000, 4'b0101, 2'd0, 1'b0), 0);
    endtask

    task automatic test_retry();
        do_op("prep_0000", 4'b0000, mk(4'b0000, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0), 0);
        drop_until = attempt_idx + 1;
        do_op("retry", 4'b0001, mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'd1, 1'b0), 0);
    endtask

    task automatic test_stuck();
        stuck_mask = 4'b1000;
        do_op("stuck", 4'b1000, mk(4'b1000, 4'b0001, 4'b1000, 4'b0000, 2'd3, 1'b1), 0);
        do_op("recover", 4'b0000, mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed();
        test_noop();
        test_retry();
        test_stuck();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
